// File: rtl/param_struct_demux_fifo_bus.sv
`default_nettype none
// ============================================================================
// Module   : param_struct_demux_fifo_bus
// Brief    : Select-field demux into per-channel FWFT FIFOs, with broadcast
//            mode and ready/valid backpressure on the input and every output.
// Revision : 1.0 - initial release
// ============================================================================
module param_struct_demux_fifo_bus #(
    parameter int DATA_WIDTH      = 32,
    parameter int BUS_WIDTH       = 4,
    parameter int SEL_WIDTH       = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEFAULT_CHANNEL = 0
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic [SEL_WIDTH-1:0]               sel_match      [0:BUS_WIDTH-1],
    input  logic                               broadcast_mode,
    input  logic [SEL_WIDTH-1:0]               sel_in,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               data_in_valid,
    output logic                               data_in_ready,
    output logic [DATA_WIDTH-1:0]              data_out       [0:BUS_WIDTH-1],
    output logic [BUS_WIDTH-1:0]               data_out_valid,
    input  logic [BUS_WIDTH-1:0]               data_out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count     [0:BUS_WIDTH-1]
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam logic [BUS_WIDTH-1:0] c_default_oh = BUS_WIDTH'(1) << DEFAULT_CHANNEL;

    logic                  r_s1_valid;
    logic [SEL_WIDTH-1:0]  r_s1_sel;
    logic [DATA_WIDTH-1:0] r_s1_data;

    logic [BUS_WIDTH-1:0]  w_match;
    logic [BUS_WIDTH-1:0]  w_target;
    logic [BUS_WIDTH-1:0]  w_full;
    logic [BUS_WIDTH-1:0]  w_push;
    logic [BUS_WIDTH-1:0]  w_pop;
    logic                  w_s1_fire;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            w_match[i] = (r_s1_sel == sel_match[i]);
        end
    end

    // x & (~x + 1) isolates the lowest set bit, giving lowest-index priority.
    always_comb begin
        if (broadcast_mode) begin
            w_target = '1;
        end else if (|w_match) begin
            w_target = w_match & (~w_match + BUS_WIDTH'(1));
        end else begin
            w_target = c_default_oh;
        end
    end

    assign w_s1_fire     = r_s1_valid & ~|(w_target & w_full);
    assign data_in_ready = ~rst & (~r_s1_valid | w_s1_fire);
    assign w_push        = {BUS_WIDTH{w_s1_fire}} & w_target;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= '0;
            r_s1_data  <= '0;
        end else if (data_in_ready) begin
            r_s1_valid <= data_in_valid;
            if (data_in_valid) begin
                r_s1_sel  <= sel_in;
                r_s1_data <= data_in;
            end
        end
    end

    for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_chan
        logic [DATA_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
        logic [c_ptr_w-1:0]    r_wr_ptr;
        logic [c_ptr_w-1:0]    r_rd_ptr;
        logic [c_cnt_w-1:0]    r_count;

        // Full looks only at the registered count, so a same-cycle pop never
        // opens room for a push; that keeps the push path off the consumer ready.
        assign w_full[g]         = (r_count == c_cnt_w'(FIFO_DEPTH));
        assign data_out_valid[g] = (r_count != '0);
        assign w_pop[g]          = data_out_valid[g] & data_out_ready[g];
        assign data_out[g]       = data_out_valid[g] ? r_mem[r_rd_ptr] : '0;
        assign fifo_count[g]     = r_count;

        always_ff @(posedge clock) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop[g]) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (w_push[g]) begin
                r_mem[r_wr_ptr] <= r_s1_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_struct_demux_fifo_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_struct_demux_fifo_bus
// Brief    : Self-checking bench with a queue-based per-channel reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_struct_demux_fifo_bus;

    localparam int DW     = 32;
    localparam int BW     = 4;
    localparam int SW     = 32;
    localparam int FD     = 4;
    localparam int DEF_CH = 0;

    logic          clock = 1'b0;
    logic          rst;
    logic [SW-1:0] sel_match [0:BW-1];
    logic          broadcast_mode;
    logic [SW-1:0] sel_in;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_out [0:BW-1];
    logic [BW-1:0] data_out_valid;
    logic [BW-1:0] data_out_ready;
    logic [2:0]    fifo_count [0:BW-1];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [DW-1:0] exp_q [BW][$];

    param_struct_demux_fifo_bus #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .SEL_WIDTH(SW),
        .FIFO_DEPTH(FD), .DEFAULT_CHANNEL(DEF_CH)
    ) dut (
        .clock(clock), .rst(rst), .sel_match(sel_match),
        .broadcast_mode(broadcast_mode), .sel_in(sel_in), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    // Routing rule: broadcast -> all, else lowest matching index, else default.
    function automatic logic [BW-1:0] ref_targets(input logic [SW-1:0] sel);
        if (broadcast_mode) return '1;
        for (int i = 0; i < BW; i++) begin
            if (sel == sel_match[i]) return BW'(1) << i;
        end
        return BW'(1) << DEF_CH;
    endfunction

    // Inputs only change just after rising edges, so the falling edge sees
    // exactly what the next rising edge will sample.
    always @(negedge clock) begin : mon
        logic [DW-1:0] e;
        logic [BW-1:0] tgt;
        if (mon_en) begin
            if (rst) begin
                for (int c = 0; c < BW; c++) exp_q[c].delete();
            end else begin
                for (int c = 0; c < BW; c++) begin
                    if (data_out_valid[c] && data_out_ready[c]) begin
                        checks++;
                        if (exp_q[c].size() == 0) begin
                            errors++;
                            $display("FAIL mon_spurious ch%0d got %h required no beat", c, data_out[c]);
                        end else begin
                            e = exp_q[c].pop_front();
                            if (data_out[c] !== e) begin
                                errors++;
                                $display("FAIL mon_order ch%0d got %h required %h", c, data_out[c], e);
                            end
                        end
                    end
                    checks++;
                    if (fifo_count[c] > 3'(FD) || data_out_valid[c] !== (fifo_count[c] != 3'd0)
                        || (!data_out_valid[c] && data_out[c] !== '0)) begin
                        errors++;
                        $display("FAIL mon_status ch%0d got count=%0d valid=%b data=%h required count<=%0d valid=(count!=0) data=0 when idle",
                                 c, fifo_count[c], data_out_valid[c], data_out[c], FD);
                    end
                end
                if (data_in_valid && data_in_ready) begin
                    tgt = ref_targets(sel_in);
                    for (int c = 0; c < BW; c++) if (tgt[c]) exp_q[c].push_back(data_in);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [SW-1:0] s, input logic [DW-1:0] d);
        int n;
        sel_in = s;
        data_in = d;
        data_in_valid = 1'b1;
        n = 0;
        while (!data_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout got ready=0 required ready within 50 cycles");
        end
        step();
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        data_in_valid = 1'b0;
        data_out_ready = '1;
        step(); step(); step();
        n = 0;
        while ((fifo_count[0] | fifo_count[1] | fifo_count[2] | fifo_count[3]) != 3'd0 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL drain_timeout got nonzero counts required empty within 50 cycles");
        end
        step(); step();
    endtask

    task automatic set_default_match();
        for (int i = 0; i < BW; i++) sel_match[i] = SW'(32'h10 + i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        broadcast_mode = 1'b0;
        sel_in = '0;
        data_in = '0;
        data_in_valid = 1'b0;
        data_out_ready = '1;
        set_default_match();
        mon_en = 1'b1;
        step(); step();
        checks++;
        if (data_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b required 0", data_in_ready);
        end
        for (int c = 0; c < BW; c++) begin
            checks++;
            if (fifo_count[c] !== 3'd0 || data_out_valid[c] !== 1'b0 || data_out[c] !== '0) begin
                errors++;
                $display("FAIL reset_state ch%0d got count=%0d valid=%b data=%h required 0/0/0",
                         c, fifo_count[c], data_out_valid[c], data_out[c]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b required 1", data_in_ready);
        end
        step();
    endtask

    task automatic test_route();
        logic [SW-1:0] t_sel [5];
        int            t_ch  [5];
        logic [DW-1:0] d;
        t_sel = '{32'h12, 32'h99, 32'h10, 32'h13, 32'h11};
        t_ch  = '{2, 0, 0, 3, 1};
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            if (k == 0) d = 32'hA5;
            send(t_sel[k], d);
            checks++;
            if (data_out_valid !== 4'b0000) begin
                errors++; $display("FAIL route_early k%0d got valid=%b required 0000", k, data_out_valid);
            end
            step();
            checks++;
            if (data_out_valid !== (4'b0001 << t_ch[k]) || data_out[t_ch[k]] !== d) begin
                errors++;
                $display("FAIL route k%0d got valid=%b data=%h required valid=%b data=%h",
                         k, data_out_valid, data_out[t_ch[k]], 4'b0001 << t_ch[k], d);
            end
            step();
            checks++;
            if (data_out_valid !== 4'b0000) begin
                errors++; $display("FAIL route_pop k%0d got valid=%b required 0000", k, data_out_valid);
            end
        end
    endtask

    task automatic test_duplicate_match();
        sel_match[3] = 32'h11;
        send(32'h11, 32'hD1);
        step();
        checks++;
        if (data_out_valid !== 4'b0010 || data_out[1] !== 32'hD1) begin
            errors++;
            $display("FAIL dup_match got valid=%b data=%h required valid=0010 data=000000d1", data_out_valid, data_out[1]);
        end
        step();
        send(32'h13, 32'hD3);
        step();
        checks++;
        if (data_out_valid !== 4'b0001 || data_out[0] !== 32'hD3) begin
            errors++;
            $display("FAIL dup_unmatched got valid=%b data=%h required valid=0001 data=000000d3", data_out_valid, data_out[0]);
        end
        step();
        drain();
        set_default_match();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got [$];
        bit acc;
        data_out_ready = 4'b1101;
        for (int k = 1; k <= 5; k++) send(32'h11, DW'(k));
        sel_in = 32'h11;
        data_in = 32'd6;
        data_in_valid = 1'b1;
        step(); step();
        checks++;
        if (fifo_count[1] !== 3'd4 || data_in_ready !== 1'b0 || data_out[1] !== 32'd1) begin
            errors++;
            $display("FAIL bp_stall got count=%0d ready=%b head=%h required 4/0/1",
                     fifo_count[1], data_in_ready, data_out[1]);
        end
        data_out_ready = '1;
        for (int c = 0; c < 30 && got.size() < 6; c++) begin
            if (data_out_valid[1]) got.push_back(data_out[1]);
            acc = data_in_valid && data_in_ready;
            step();
            if (acc) data_in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL bp_count_out got %0d required 6", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== DW'(k + 1)) begin
                errors++; $display("FAIL bp_order idx%0d got %h required %h", k, got[k], k + 1);
            end
        end
        drain();
    endtask

    task automatic test_broadcast();
        broadcast_mode = 1'b1;
        data_out_ready = 4'b0111;
        for (int k = 0; k < 4; k++) send($urandom, 32'hB0 + k);
        step(); step();
        send(32'h55, 32'h77);
        step(); step();
        checks++;
        if (fifo_count[3] !== 3'd4 || data_out_valid !== 4'b1000 || data_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bc_stall got count3=%0d valid=%b ready=%b required 4/1000/0",
                     fifo_count[3], data_out_valid, data_in_ready);
        end
        data_out_ready[3] = 1'b1;
        step();
        data_out_ready[3] = 1'b0;
        checks++;
        if (fifo_count[3] !== 3'd3 || data_out_valid !== 4'b1000) begin
            errors++;
            $display("FAIL bc_pop got count3=%0d valid=%b required 3/1000", fifo_count[3], data_out_valid);
        end
        step();
        checks++;
        if (fifo_count[3] !== 3'd4 || data_out_valid !== 4'b1111 || data_out[0] !== 32'h77
            || data_out[1] !== 32'h77 || data_out[2] !== 32'h77) begin
            errors++;
            $display("FAIL bc_push got count3=%0d valid=%b d0=%h d1=%h d2=%h required 4/1111/77/77/77",
                     fifo_count[3], data_out_valid, data_out[0], data_out[1], data_out[2]);
        end
        drain();
        broadcast_mode = 1'b0;
    endtask

    task automatic test_full_concurrent_pop();
        data_out_ready = 4'b1110;
        for (int k = 0; k < 5; k++) send(32'h10, 32'hC0 + k);
        checks++;
        if (fifo_count[0] !== 3'd4 || data_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fcp_full got count0=%0d ready=%b required 4/0", fifo_count[0], data_in_ready);
        end
        data_out_ready[0] = 1'b1;
        step();
        data_out_ready[0] = 1'b0;
        checks++;
        if (fifo_count[0] !== 3'd3 || data_out[0] !== 32'hC1) begin
            errors++;
            $display("FAIL fcp_pop got count0=%0d head=%h required 3/c1", fifo_count[0], data_out[0]);
        end
        step();
        checks++;
        if (fifo_count[0] !== 3'd4 || data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fcp_push got count0=%0d ready=%b required 4/1", fifo_count[0], data_in_ready);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        logic [SW-1:0] s [7];
        s = '{32'h10, 32'h10, 32'h11, 32'h13, 32'h13, 32'h13, 32'h12};
        data_out_ready = '0;
        for (int k = 0; k < 7; k++) send(s[k], $urandom);
        checks++;
        if (fifo_count[0] !== 3'd2 || fifo_count[1] !== 3'd1 || fifo_count[2] !== 3'd0 || fifo_count[3] !== 3'd3) begin
            errors++;
            $display("FAIL rmid_setup got counts=%0d,%0d,%0d,%0d required 2,1,0,3",
                     fifo_count[0], fifo_count[1], fifo_count[2], fifo_count[3]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (data_in_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_ready_during got %b required 0", data_in_ready);
        end
        step();
        for (int c = 0; c < BW; c++) begin
            checks++;
            if (fifo_count[c] !== 3'd0 || data_out_valid[c] !== 1'b0 || data_out[c] !== '0) begin
                errors++;
                $display("FAIL rmid_state ch%0d got count=%0d valid=%b data=%h required 0/0/0",
                         c, fifo_count[c], data_out_valid[c], data_out[c]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready_after got %b required 1", data_in_ready);
        end
        data_out_ready = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (data_out_valid !== 4'b0000) begin
                errors++; $display("FAIL rmid_stale cyc%0d got valid=%b required 0000", k, data_out_valid);
            end
        end
    endtask

    task automatic test_random();
        int left;
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < BW; i++) sel_match[i] = SW'(32'h10 + $urandom_range(0, 3));
            broadcast_mode = (phase == 1);
            for (int n = 0; n < 400; n++) begin
                data_in_valid = ($urandom_range(0, 3) != 0);
                sel_in = ($urandom_range(0, 4) == 0) ? SW'($urandom) : SW'(32'h10 + $urandom_range(0, 4));
                data_in = $urandom;
                data_out_ready = BW'($urandom);
                step();
            end
            drain();
            left = 0;
            for (int c = 0; c < BW; c++) left += exp_q[c].size();
            checks++;
            if (left != 0) begin
                errors++; $display("FAIL rand_lost phase%0d got %0d undelivered beats required 0", phase, left);
            end
        end
        broadcast_mode = 1'b0;
        set_default_match();
    endtask

    initial begin
        test_reset();
        test_route();
        test_duplicate_match();
        test_backpressure();
        test_broadcast();
        test_full_concurrent_pop();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
